aes_stream_packer: RTL and testbench
====================================

AES_STREAM_PACKER -- requirements
Module: aes_stream_packer

Interface
REQ-001 Parameter WAIT_DONE, default 1: 1 = hold each issued block until aes_done; 0 = issue back-to-back, ignoring aes_done.
REQ-002 clk  input  1  single system clock; all logic on posedge clk.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 in_byte  input  8  plaintext/ciphertext stream byte.
REQ-005 inclk  input  1  one-cycle strobe; in_byte valid this cycle.
REQ-006 in_last  input  1  qualifies inclk; marks final byte of a frame.
REQ-007 in_ready  output  1  high when a byte strobe is accepted this cycle.
REQ-008 aes_done  input  1  one-cycle strobe from downstream aes_combined outclk.
REQ-009 out  output  128  assembled block for aes_combined in.
REQ-010 outclk  output  1  one-cycle strobe, out valid; drives aes_combined inclk.
REQ-011 out_last  output  1  qualifies outclk; block is the frame's last.
REQ-012 busy  output  1  high in any state except FILL with zero bytes held.

Function
REQ-013 The block SHALL pack bytes MSB-first: the first byte of a block lands in out[127:120], the 16th in out[7:0].
REQ-014 States SHALL be FILL, PAD, ISSUE, WAIT; reset state FILL, byte count 0.
REQ-015 FILL: in_ready=1; an accepted byte is stored at the count position and the 4-bit count increments; inclk while in_ready=0 SHALL be ignored (byte dropped, no state change).
REQ-016 FILL -> ISSUE when the 16th byte is accepted; FILL -> PAD when in_last is accepted with count<16 after increment.
REQ-017 PAD: fill remaining positions per REQ-026/027 in one cycle, then -> ISSUE.
REQ-018 ISSUE: outclk=1 for exactly one cycle with out and out_last stable; out holds its value until the next outclk.
REQ-019 ISSUE -> WAIT if WAIT_DONE=1, else -> FILL (count cleared); in_ready=0 in PAD, ISSUE, WAIT.
REQ-020 WAIT -> FILL on aes_done; aes_done in any other state SHALL be ignored.
REQ-021 Latency: outclk asserts 1 cycle after the 16th byte is accepted, 2 cycles after a short in_last byte.
REQ-022 in_last on the 16th byte SHALL set out_last on that block; with AES_PAD_EN an extra full pad block follows (REQ-026).
REQ-023 Maximum throughput with WAIT_DONE=0: one block per 17 cycles (16 FILL + 1 ISSUE).

Reset
REQ-024 While rst_n=0 at posedge clk: state FILL, count 0, out=0, outclk=0, out_last=0, busy=0, in_ready=0; in_ready=1 the cycle after release.
REQ-025 Reset asserted mid-block or in WAIT SHALL discard the partial block with no outclk emitted.

Configuration
REQ-026 With AES_PAD_EN defined: PKCS#7 padding; each pad byte equals 16-n (n = data bytes in block, 1..16); a frame ending on a full block emits one extra block of sixteen 0x10 bytes, only that block carrying out_last.
REQ-027 Without AES_PAD_EN: pad bytes are 0x00; no extra block; out_last on the block containing the last data byte.

Structure
REQ-028 A shared package aes_pkg SHALL hold AES_BLOCK_BYTES=16, AES_BLOCK_BITS=128 and the packer state enum.
REQ-029 No sub-module; single module with one state register process and one datapath process.

Verification
REQ-030 16 bytes 0x00..0x0F, last on 0x0F, pad on -> out=000102..0F, out_last=0, then 2nd block all 0x10 with out_last=1.
REQ-031 Bytes 0xAA,0xBB,0xCC (last on 0xCC), pad on -> out=AABBCC0D0D..0D, out_last=1, outclk 2 cycles after 0xCC; pad off -> AABBCC00..00.
REQ-032 WAIT_DONE=1, 20 bytes streamed every cycle -> bytes 17..20 strobed while in_ready=0 are dropped; aes_done after 10 cycles -> FILL resumes with count 0.
REQ-033 rst_n=0 after 7 bytes accepted -> no outclk, busy=0; next 16 bytes yield a block holding only the new bytes.
REQ-034 aes_done pulsed in FILL and ISSUE -> no state change; WAIT_DONE=0 back-to-back 32 bytes -> two outclk pulses 17 cycles apart.

Source files
------------

// File: rtl/aes_pkg.sv
// AES stream packer shared types and constants.
// Block geometry, packer state enum, pad byte helper.
package aes_pkg;

  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_BLOCK_BITS  = 128;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_PAD,
    ST_ISSUE,
    ST_WAIT
  } pk_state_e;

  // n data bytes held; PKCS#7 pads with 16-n, else zero
  function automatic logic [7:0] pad_byte(
    input logic [3:0] n,
    input logic       pkcs
  );
    logic [4:0] v;
    v = 5'd16 - {1'b0, n};
    pad_byte = pkcs ? {3'b000, v} : 8'h00;
  endfunction

endpackage

// File: rtl/aes_stream_packer.sv
// Byte stream to 128-bit block packer for aes_combined.
// Define AES_PAD_EN for PKCS#7 padding; default pads with zeros.
module aes_stream_packer
  import aes_pkg::*;
#(
  parameter bit WAIT_DONE = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                in_byte,
  input  logic                      inclk,
  input  logic                      in_last,
  output logic                      in_ready,
  input  logic                      aes_done,
  output logic [AES_BLOCK_BITS-1:0] out,
  output logic                      outclk,
  output logic                      out_last,
  output logic                      busy
);

`ifdef AES_PAD_EN
  localparam logic PKCS = 1'b1;
`else
  localparam logic PKCS = 1'b0;
`endif

  pk_state_e                 state_q;
  pk_state_e                 state_d;
  logic [3:0]                cnt_q;
  logic [AES_BLOCK_BITS-1:0] buf_q;
  logic [AES_BLOCK_BITS-1:0] out_q;
  logic                      last_q;
  logic                      pend_q;
  logic                      accept;
  logic [AES_BLOCK_BITS-1:0] fill_blk;
  logic [AES_BLOCK_BITS-1:0] pad_blk;
  logic [7:0]                pad_v;

  assign in_ready = rst_n && (state_q == ST_FILL);
  assign accept   = inclk && in_ready;
  assign outclk   = (state_q == ST_ISSUE);
  assign out      = out_q;
  assign out_last = last_q;
  assign busy     = !((state_q == ST_FILL) && (cnt_q == 4'd0));
  assign pad_v    = pad_byte(cnt_q, PKCS);

  // Candidate blocks: buffer with new byte, buffer with padding
  always_comb begin
    fill_blk = buf_q;
    pad_blk  = buf_q;
    for (int i = 0; i < AES_BLOCK_BYTES; i++) begin
      if (accept && (cnt_q == 4'(i)))
        fill_blk[AES_BLOCK_BITS-1-8*i -: 8] = in_byte;
      if (4'(i) >= cnt_q)
        pad_blk[AES_BLOCK_BITS-1-8*i -: 8] = pad_v;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FILL: begin
        if (accept) begin
          if (cnt_q == 4'd15)
            state_d = ST_ISSUE;
          else if (in_last)
            state_d = ST_PAD;
        end
      end
      ST_PAD: state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (WAIT_DONE)
          state_d = ST_WAIT;
        else if (pend_q)
          state_d = ST_PAD;
        else
          state_d = ST_FILL;
      end
      ST_WAIT: begin
        if (aes_done)
          state_d = pend_q ? ST_PAD : ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n)
      state_q <= ST_FILL;
    else
      state_q <= state_d;
  end

  // Byte buffer, count and issued block registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      buf_q  <= '0;
      out_q  <= '0;
      last_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_FILL: begin
          if (accept) begin
            buf_q <= fill_blk;
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              out_q  <= fill_blk;
              last_q <= in_last && !PKCS;
              pend_q <= in_last && PKCS;
            end
          end
        end
        ST_PAD: begin
          out_q  <= pad_blk;
          last_q <= 1'b1;
          pend_q <= 1'b0;
        end
        ST_ISSUE: cnt_q <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_stream_packer.sv
// Self-checking bench for aes_stream_packer.
// Two instances: WAIT_DONE=1 (dut1) and WAIT_DONE=0 (dut0).
module tb_aes_stream_packer;

`ifdef AES_PAD_EN
  localparam bit PKCS = 1'b1;
`else
  localparam bit PKCS = 1'b0;
`endif

  typedef struct {
    logic [127:0] d;
    logic         last;
    int           cyc;
  } blk_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   in_byte = 8'h00;
  logic         inclk = 1'b0;
  logic         in_last = 1'b0;
  logic         aes_done = 1'b0;
  logic         rdy1, oc1, ol1, busy1;
  logic         rdy0, oc0, ol0, busy0;
  logic [127:0] o1, o0;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rd1 = 0;
  int   rd0 = 0;
  bit   auto_done = 1'b0;
  blk_t got1[$];
  blk_t got0[$];
  blk_t exp_q[$];

  aes_stream_packer #(.WAIT_DONE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_byte(in_byte),
    .inclk(inclk), .in_last(in_last), .in_ready(rdy1),
    .aes_done(aes_done), .out(o1), .outclk(oc1),
    .out_last(ol1), .busy(busy1)
  );

  aes_stream_packer #(.WAIT_DONE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_byte(in_byte),
    .inclk(inclk), .in_last(in_last), .in_ready(rdy0),
    .aes_done(aes_done), .out(o0), .outclk(oc0),
    .out_last(ol0), .busy(busy0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (oc1) got1.push_back('{o1, ol1, cyc});
    if (oc0) got0.push_back('{o0, ol0, cyc});
  end

  task automatic chkb(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkw(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference block: n data bytes from q[st..], rest filled with padv
  function automatic logic [127:0] pack(
    input logic [7:0] q[$], input int st,
    input int n, input logic [7:0] padv
  );
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < n) r[127-8*i -: 8] = q[st+i];
      else       r[127-8*i -: 8] = padv;
    end
    return r;
  endfunction

  // Expected blocks for one whole frame ending with in_last
  task automatic model(input logic [7:0] f[$]);
    int n, nf, rem;
    logic [7:0] pv;
    n   = f.size();
    nf  = n / 16;
    rem = n % 16;
    for (int b = 0; b < nf; b++)
      exp_q.push_back('{pack(f, 16*b, 16, 8'h00),
                        (b == nf-1) && (rem == 0) && !PKCS, 0});
    if (rem > 0) begin
      pv = PKCS ? 8'(16 - rem) : 8'h00;
      exp_q.push_back('{pack(f, 16*nf, rem, pv), 1'b1, 0});
    end else if (PKCS) begin
      exp_q.push_back('{pack(f, 0, 0, 8'h10), 1'b1, 0});
    end
  endtask

  task automatic send(input logic [7:0] b, input logic last, input bit sel);
    int n = 0;
    while (!(sel ? rdy1 : rdy0) && n < 300) begin
      aes_done = auto_done && ($urandom_range(0, 2) == 0);
      tick;
      aes_done = 1'b0;
      n++;
    end
    if (!(sel ? rdy1 : rdy0))
      chkb("ready_timeout", sel ? rdy1 : rdy0, 1'b1);
    in_byte = b;
    inclk   = 1'b1;
    in_last = last;
    tick;
    inclk   = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      aes_done = ($urandom_range(0, 1) == 1);
      tick;
      aes_done = 1'b0;
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    #1;
    rd1 = got1.size();
    rd0 = got0.size();
  endtask

  task automatic chk_blk(string tag, bit sel, logic [127:0] ed, logic el);
    int avail;
    blk_t g;
    avail = sel ? got1.size() - rd1 : got0.size() - rd0;
    chkb({tag, "_avail"}, avail > 0, 1'b1);
    if (avail > 0) begin
      if (sel) begin g = got1[rd1]; rd1++; end
      else     begin g = got0[rd0]; rd0++; end
      chkw({tag, "_data"}, g.d, ed);
      chkb({tag, "_last"}, g.last, el);
    end
  endtask

  task automatic check_exp(string tag);
    chki({tag, "_n1"}, got1.size() - rd1, exp_q.size());
    chki({tag, "_n0"}, got0.size() - rd0, exp_q.size());
    foreach (exp_q[i]) begin
      chk_blk({tag, "_w1"}, 1'b1, exp_q[i].d, exp_q[i].last);
      chk_blk({tag, "_w0"}, 1'b0, exp_q[i].d, exp_q[i].last);
    end
    exp_q = {};
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]   q[$];
    logic [127:0] e;
    int           lens[6];

    // Reset state
    rst_n = 1'b0;
    tick;
    tick;
    chkb("rst_ready", rdy1, 1'b0);
    chkb("rst_outclk", oc1, 1'b0);
    chkw("rst_out", o1, 128'h0);
    chkb("rst_last", ol1, 1'b0);
    chkb("rst_busy", busy1, 1'b0);
    chkw("rst_out0", o0, 128'h0);
    rst_n = 1'b1;
    #1;
    chkb("rel_ready", rdy1, 1'b1);
    rd1 = got1.size();
    rd0 = got0.size();

    // Short frame AA BB CC, latency 2
    q = {8'hAA, 8'hBB, 8'hCC};
    e = pack(q, 0, 3, PKCS ? 8'h0D : 8'h00);
    send(8'hAA, 1'b0, 1'b1);
    send(8'hBB, 1'b0, 1'b1);
    send(8'hCC, 1'b1, 1'b1);
    chkb("short_lat1", oc1, 1'b0);
    tick;
    chkb("short_lat2", oc1, 1'b1);
    chkw("short_out", o1, e);
    chkb("short_last", ol1, 1'b1);
    tick;
    chkb("short_wait_rdy", rdy1, 1'b0);
    chkw("short_hold", o1, e);
    aes_done = 1'b1;
    tick;
    aes_done = 1'b0;
    chkb("short_done_rdy", rdy1, 1'b1);
    chkb("short_done_busy", busy1, 1'b0);
    chk_blk("short0", 1'b0, e, 1'b1);
    rd1 = got1.size();

    // Full 16-byte frame 00..0F, last on 0F
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(8'(i));
    model(q);
    foreach (q[i]) send(q[i], i == 15, 1'b1);
    drain(40);
    check_exp("full16");

    // 20 bytes every cycle: 17..20 dropped
    do_reset;
    for (int i = 1; i <= 20; i++) begin
      in_byte = 8'(i);
      inclk = 1'b1;
      if (i >= 17) chkb("drop_rdy", rdy1, 1'b0);
      tick;
    end
    inclk = 1'b0;
    repeat (10) tick;
    chkb("wait_busy", busy1, 1'b1);
    aes_done = 1'b1;
    tick;
    aes_done = 1'b0;
    chkb("resume_rdy", rdy1, 1'b1);
    chkb("resume_busy", busy1, 1'b0);
    q = {};
    for (int i = 1; i <= 16; i++) q.push_back(8'(i));
    chk_blk("drop_blk", 1'b1, pack(q, 0, 16, 8'h00), 1'b0);
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(8'(8'h40 + i));
    foreach (q[i]) send(q[i], 1'b0, 1'b1);
    tick;
    chk_blk("after_drop", 1'b1, pack(q, 0, 16, 8'h00), 1'b0);

    // Reset mid-block discards partial data
    do_reset;
    for (int i = 0; i < 7; i++) send(8'($urandom), 1'b0, 1'b1);
    chkb("part_busy", busy1, 1'b1);
    rst_n = 1'b0;
    tick;
    tick;
    chkb("mid_rst_busy", busy1, 1'b0);
    chkb("mid_rst_oc", oc1, 1'b0);
    chki("mid_rst_noout", got1.size() - rd1, 0);
    rst_n = 1'b1;
    #1;
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(8'(8'h80 + i));
    foreach (q[i]) send(q[i], 1'b0, 1'b1);
    tick;
    chk_blk("post_rst", 1'b1, pack(q, 0, 16, 8'h00), 1'b0);

    // aes_done in FILL and ISSUE is ignored
    do_reset;
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(8'($urandom));
    for (int i = 0; i < 3; i++) send(q[i], 1'b0, 1'b1);
    aes_done = 1'b1;
    tick;
    aes_done = 1'b0;
    chkb("fill_done_busy", busy1, 1'b1);
    chkb("fill_done_rdy", rdy1, 1'b1);
    for (int i = 3; i < 16; i++) send(q[i], 1'b0, 1'b1);
    chkb("issue_oc", oc1, 1'b1);
    aes_done = 1'b1;
    tick;
    aes_done = 1'b0;
    chkb("issue_done_rdy", rdy1, 1'b0);
    tick;
    chkb("issue_done_rdy2", rdy1, 1'b0);
    aes_done = 1'b1;
    tick;
    aes_done = 1'b0;
    chkb("wait_done_rdy", rdy1, 1'b1);
    chk_blk("ign_blk", 1'b1, pack(q, 0, 16, 8'h00), 1'b0);

    // WAIT_DONE=0: 32 bytes back-to-back, 17 cycles apart
    do_reset;
    q = {};
    for (int i = 0; i < 32; i++) q.push_back(8'($urandom));
    foreach (q[i]) send(q[i], 1'b0, 1'b0);
    tick;
    tick;
    chki("b2b_count", got0.size() - rd0, 2);
    if (got0.size() - rd0 >= 2)
      chki("b2b_gap", got0[rd0+1].cyc - got0[rd0].cyc, 17);
    chk_blk("b2b_a", 1'b0, pack(q, 0, 16, 8'h00), 1'b0);
    chk_blk("b2b_b", 1'b0, pack(q, 16, 16, 8'h00), 1'b0);

    // Random frames against the reference model
    do_reset;
    auto_done = 1'b1;
    lens[0] = 16;
    lens[1] = 1;
    lens[2] = 15;
    lens[3] = 32;
    lens[4] = $urandom_range(2, 40);
    lens[5] = $urandom_range(2, 40);
    foreach (lens[f]) begin
      q = {};
      for (int i = 0; i < lens[f]; i++) q.push_back(8'($urandom));
      model(q);
      foreach (q[i]) send(q[i], i == lens[f] - 1, 1'b1);
    end
    drain(150);
    check_exp("rand");
    auto_done = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
